// File: rtl/crp16_alu_seq_pkg.sv
// Shared definitions for the CRP16 ALU request/response sequencer:
// FSM state encodings, ALU mode constants, flag bit positions and a
// helper that packs the four ALU flags into the {v,c,n,z} layout.
package crp16_alu_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // ALU mode field, select bits [3:2]
    localparam logic [1:0] MODE_ARITH = 2'b00;
    localparam logic [1:0] MODE_SLT   = 2'b01;
    localparam logic [1:0] MODE_LOGIC = 2'b10;
    localparam logic [1:0] MODE_SHIFT = 2'b11;

    // Plain add select, used to double the accumulator during shifts
    localparam logic [3:0] SEL_ADD = 4'b0000;

    // Flag bit positions inside the 4-bit flag vectors
    localparam int FLAG_V = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

    function automatic logic [3:0] pack_flags(input logic v, input logic c,
                                              input logic n, input logic z);
        logic [3:0] f;
        f         = 4'b0000;
        f[FLAG_V] = v;
        f[FLAG_C] = c;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        return f;
    endfunction

endpackage

// File: rtl/crp16_alu_seq_shift_ctr.sv
// 4-bit loadable down-counter holding the remaining shift steps.
// done is high while the count is zero; decrementing stops at zero.
// Only present when CRP16_ALU_SEQ_SHIFT_EN is defined.
`ifdef CRP16_ALU_SEQ_SHIFT_EN
module crp16_alu_seq_shift_ctr (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_value,
    input  logic       dec,
    output logic [3:0] count,
    output logic       done
);

    // Load wins over decrement; the count never wraps below zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= 4'd0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != 4'd0)) begin
            count <= count - 4'd1;
        end
    end

    assign done = (count == 4'd0);

endmodule
`endif

// File: rtl/crp16_alu_seq.sv
// CRP16 ALU request/response sequencer. Accepts one operation at a time,
// drives the external ALU from registers, captures result and flags and
// returns them over a response handshake. Keeps a status flag register.
// Build option CRP16_ALU_SEQ_SHIFT_EN enables multi-cycle left shifts built
// from repeated x+x passes through the ALU adder; without it, shift-mode
// ops complete with resp_err set and a zero result.
module crp16_alu_seq
    import crp16_alu_seq_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_x,
    input  logic [15:0] req_y,
    input  logic [3:0]  req_op,
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    output logic [3:0]  alu_select,
    input  logic [15:0] alu_result,
    input  logic        alu_v,
    input  logic        alu_c,
    input  logic        alu_n,
    input  logic        alu_z,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [15:0] resp_result,
    output logic [3:0]  resp_flags,
    output logic        resp_err,
    output logic [3:0]  status_flags
);

    state_t state, next_state;
    logic   req_shift;
    logic   err_q;
    logic [3:0] alu_flags;

    assign req_shift = (req_op[3:2] == MODE_SHIFT);
    assign alu_flags = pack_flags(alu_v, alu_c, alu_n, alu_z);

`ifdef CRP16_ALU_SEQ_SHIFT_EN
    logic [3:0]  shift_count;
    logic        shift_done;
    logic        shift_last;
    logic [15:0] shift_result;
    logic        shift_c;
    logic [3:0]  shift_flags;

    // The accumulator lives in alu_x/alu_y, so the count alone tracks progress.
    crp16_alu_seq_shift_ctr u_shift_ctr (
        .clock      (clock),
        .reset      (reset),
        .load       ((state == ST_IDLE) && req_valid && req_shift),
        .load_value (req_y[3:0]),
        .dec        (state == ST_SHIFT),
        .count      (shift_count),
        .done       (shift_done)
    );

    // Last SHIFT cycle: either a zero-length shift or the final doubling.
    assign shift_last   = shift_done || (shift_count == 4'd1);
    // A zero-length shift returns x untouched with carry clear.
    assign shift_result = shift_done ? alu_x : alu_result;
    assign shift_c      = shift_done ? 1'b0  : alu_c;
    assign shift_flags  = pack_flags(1'b0, shift_c, 1'b0, shift_result == 16'h0000);
`endif

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    // NOTE: next_state gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
`ifdef CRP16_ALU_SEQ_SHIFT_EN
                    next_state = req_shift ? ST_SHIFT : ST_EXEC;
`else
                    next_state = ST_EXEC;
`endif
                end
            end
            ST_EXEC: next_state = ST_RESP;
            ST_SHIFT: begin
`ifdef CRP16_ALU_SEQ_SHIFT_EN
                if (shift_last) next_state = ST_RESP;
`else
                next_state = ST_IDLE;
`endif
            end
            ST_RESP: begin
                if (resp_ready) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state.
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            ST_IDLE: req_ready  = 1'b1;
            ST_RESP: resp_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: operand latch, shift accumulator, response and status capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            alu_x        <= 16'h0000;
            alu_y        <= 16'h0000;
            alu_select   <= 4'h0;
            err_q        <= 1'b0;
            resp_result  <= 16'h0000;
            resp_flags   <= 4'h0;
            resp_err     <= 1'b0;
            status_flags <= 4'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (req_shift) begin
`ifdef CRP16_ALU_SEQ_SHIFT_EN
                            alu_x      <= req_x;
                            alu_y      <= req_x;
                            alu_select <= SEL_ADD;
                            err_q      <= 1'b0;
`else
                            // Unsupported op: ALU operands keep their old values.
                            err_q      <= 1'b1;
`endif
                        end else begin
                            alu_x      <= req_x;
                            alu_y      <= req_y;
                            alu_select <= req_op;
                            err_q      <= 1'b0;
                        end
                    end
                end
                ST_EXEC: begin
                    if (err_q) begin
                        resp_result <= 16'h0000;
                        resp_flags  <= 4'h0;
                        resp_err    <= 1'b1;
                    end else begin
                        resp_result  <= alu_result;
                        resp_flags   <= alu_flags;
                        resp_err     <= 1'b0;
                        status_flags <= alu_flags;
                    end
                end
`ifdef CRP16_ALU_SEQ_SHIFT_EN
                ST_SHIFT: begin
                    if (!shift_done) begin
                        alu_x <= alu_result;
                        alu_y <= alu_result;
                    end
                    if (shift_last) begin
                        resp_result  <= shift_result;
                        resp_flags   <= shift_flags;
                        resp_err     <= 1'b0;
                        status_flags <= shift_flags;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
